// File: rtl/dpram_read_streamer.sv
// -----------------------------------------------------------------------------
// dpram_read_streamer
//
// Reads a contiguous block of words out of the dual-port buffer RAM read port
// and presents them, in order, on a valid/ready stream towards the PE array
// feeder. A small skid FIFO sized to the RAM read latency, together with an
// issue credit check, ensures no word is lost or duplicated under
// backpressure.
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   start      1-cycle command pulse, honoured only while idle
//   base_addr  first RAM address of the command
//   len        number of words, 0..2^AW
//   busy       command in progress (streaming state)
//   done       1-cycle pulse once the command has completed
//   enb        RAM read enable, one read per asserted cycle
//   addrb      RAM read address
//   dob        RAM read data, valid N_DELAY cycles after enb
//   m_valid    output word valid
//   m_ready    downstream accept
//   m_data     output word (FIFO head)
//   m_last     marks the final word of the command
// -----------------------------------------------------------------------------
module dpram_read_streamer #(
  parameter int DW      = 32,
  parameter int AW      = 16,
  parameter int N_DELAY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          enb,
  output logic [AW-1:0] addrb,
  input  logic [DW-1:0] dob,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
);

  // Skid FIFO depth: enough to absorb every read that can still be in
  // flight when the consumer stalls, plus the word currently presented.
  localparam int D  = N_DELAY + 1;
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  // Wide enough for inflight + occ without overflow.
  localparam int CW = $clog2(D + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;

  logic [AW-1:0]  r_addr_cnt;
  logic [AW:0]    r_issue_rem;
  logic [AW:0]    r_out_rem;

  logic [N_DELAY-1:0] r_vld_sr;
  logic [CW-1:0]      r_inflight;
  logic               w_ret;

  logic [DW-1:0] r_mem [D];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_occ;

  logic          w_pop;
  logic [CW-1:0] w_level;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = (len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_pop && m_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Issue side
  // ---------------------------------------------------------------------------
  assign w_pop = m_valid & m_ready;

  // Credits: a new read may go out only if, after this cycle's pop, every
  // word already owed to the FIFO plus this one still fits.
  assign w_level = r_inflight + r_occ - CW'(w_pop);
  assign enb     = (r_state == S_RUN) && (r_issue_rem != '0) && (w_level < CW'(D));
  assign addrb   = r_addr_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_cnt  <= '0;
      r_issue_rem <= '0;
      r_out_rem   <= '0;
    end else if (w_accept) begin
      r_addr_cnt  <= base_addr;
      r_issue_rem <= len;
      r_out_rem   <= len;
    end else begin
      if (enb) begin
        r_addr_cnt  <= r_addr_cnt + AW'(1);
        r_issue_rem <= r_issue_rem - (AW+1)'(1);
      end
      if (w_pop) r_out_rem <= r_out_rem - (AW+1)'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Return path: the shifted enable marks the one cycle in which dob carries
  // the answer to an earlier read. Outside that cycle dob is ignored.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_sr <= '0;
    end else begin
      r_vld_sr[0] <= enb;
      for (int i = 1; i < N_DELAY; i++) r_vld_sr[i] <= r_vld_sr[i-1];
    end
  end

  assign w_ret = r_vld_sr[N_DELAY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({enb, w_ret})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Skid FIFO (first-word fall-through). Push and pop in the same cycle leave
  // occupancy unchanged; separate pointers keep the order intact.
  // ---------------------------------------------------------------------------
  // NOTE: the storage is reset on purpose: it is only D words, and clearing
  // it keeps m_data at zero after reset instead of leaking stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_ret) begin
        r_mem[r_wr_ptr] <= dob;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_ret, w_pop})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stream outputs
  // ---------------------------------------------------------------------------
  assign m_valid = (r_occ != '0);
  assign m_data  = r_mem[r_rd_ptr];
  assign m_last  = m_valid && (r_out_rem == (AW+1)'(1));

endmodule
